// File: rtl/mini_bus_pkg.sv
// Shared encodings and default widths for the mini CPU bus.
package mini_bus_pkg;

   localparam int unsigned BUS_ADDR_W = 8;
   localparam int unsigned BUS_DATA_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   typedef enum logic {
      OP_RD = 1'b0,
      OP_WR = 1'b1
   } op_t;

endpackage

// File: rtl/mini_sp_ram.sv
// Single-port synchronous RAM; read data is registered only when re is set.
module mini_sp_ram #(
   parameter int unsigned AW     = 8,
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DEPTH  = 256
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              re,
   input  logic              we,
   input  logic [AW-1:0]     addr,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout
);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_dout;

   // Array contents survive reset; only the output register clears.
   always_ff @(posedge clk) begin
      if (we) begin
         r_mem[addr] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_dout <= '0;
      end else if (re) begin
         r_dout <= r_mem[addr];
      end
   end

   assign dout = r_dout;

endmodule

// File: rtl/mini_mem_responder.sv
// Memory-side responder for the mini CPU bus: captures a strobe, inserts
// WAIT_CYC wait states, then completes with a one-cycle ready pulse.
module mini_mem_responder
   import mini_bus_pkg::*;
#(
   parameter int unsigned ADDR_W   = BUS_ADDR_W,
   parameter int unsigned DATA_W   = BUS_DATA_W,
   parameter int unsigned DEPTH    = 256,
   parameter int unsigned WAIT_CYC = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rd_req,
   input  logic              wr_req,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              ready,
   output logic              busy,
   output logic              err
);

   localparam int unsigned CNT_W  = 4;
   localparam int unsigned RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   state_t              r_state, w_state_nxt;
   logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata;
   op_t                 r_op;
   logic                r_ready, r_busy, r_err;
   logic                w_ready_nxt, w_busy_nxt, w_err_nxt;
   logic                w_latch, w_re, w_we, w_oob;
   logic [ADDR_W-1:0]   w_addr_mux;
   logic [RAM_AW-1:0]   w_ram_addr;

   // In IDLE the live address feeds the RAM so a zero-wait read lands in RESP.
   assign w_addr_mux = (r_state == ST_IDLE) ? addr : r_addr;
   assign w_oob      = (32'(w_addr_mux) >= DEPTH);
   assign w_ram_addr = RAM_AW'(w_addr_mux);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_ready <= 1'b0;
         r_busy  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_ready <= w_ready_nxt;
         r_busy  <= w_busy_nxt;
         r_err   <= w_err_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (w_latch) begin
         r_addr  <= addr;
         r_wdata <= wdata;
         r_op    <= wr_req ? OP_WR : OP_RD;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_latch     = 1'b0;
      w_ready_nxt = 1'b0;
      w_busy_nxt  = 1'b0;
      w_err_nxt   = 1'b0;
      w_re        = 1'b0;
      w_we        = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (rd_req ^ wr_req) begin
               w_latch    = 1'b1;
               w_busy_nxt = 1'b1;
               if (WAIT_CYC == 0) begin
                  w_state_nxt = ST_RESP;
                  w_ready_nxt = 1'b1;
                  w_err_nxt   = w_oob;
                  w_re        = rd_req & ~w_oob;
               end else begin
                  w_state_nxt = ST_WAIT;
                  w_cnt_nxt   = CNT_W'(WAIT_CYC);
               end
            end else if (rd_req & wr_req) begin
               w_err_nxt = 1'b1;
            end
         end
         ST_WAIT: begin
            w_busy_nxt = 1'b1;
            if (r_cnt == CNT_W'(1)) begin
               w_state_nxt = ST_RESP;
               w_cnt_nxt   = '0;
               w_ready_nxt = 1'b1;
               w_err_nxt   = w_oob;
               w_re        = (r_op == OP_RD) & ~w_oob;
            end else begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end
         end
         ST_RESP: begin
            w_state_nxt = ST_IDLE;
            w_we        = (r_op == OP_WR) & ~w_oob;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Reset during RESP must drop the pending write.
   mini_sp_ram #(
      .AW     (RAM_AW),
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_ram (
      .clk   (clk),
      .rst_n (rst_n),
      .re    (w_re),
      .we    (w_we & rst_n),
      .addr  (w_ram_addr),
      .din   (r_wdata),
      .dout  (rdata)
   );

   assign ready = r_ready;
   assign busy  = r_busy;
   assign err   = r_err;

endmodule

// File: tb/tb_mini_mem_responder.sv
// Directed bench: three responders (2 waits/256 deep, 0 waits, 2 waits/128 deep).
module tb_mini_mem_responder;

   localparam int unsigned NDUT = 3;

   logic       clk = 1'b0;
   logic       rst_n [NDUT];
   logic       rd    [NDUT];
   logic       wr    [NDUT];
   logic [7:0] addr  [NDUT];
   logic [7:0] wdata [NDUT];
   logic [7:0] rdata [NDUT];
   logic       ready [NDUT];
   logic       busy  [NDUT];
   logic       err   [NDUT];

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   mini_mem_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(256), .WAIT_CYC(2)) u_w2 (
      .clk(clk), .rst_n(rst_n[0]), .rd_req(rd[0]), .wr_req(wr[0]), .addr(addr[0]),
      .wdata(wdata[0]), .rdata(rdata[0]), .ready(ready[0]), .busy(busy[0]), .err(err[0]));

   mini_mem_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(256), .WAIT_CYC(0)) u_w0 (
      .clk(clk), .rst_n(rst_n[1]), .rd_req(rd[1]), .wr_req(wr[1]), .addr(addr[1]),
      .wdata(wdata[1]), .rdata(rdata[1]), .ready(ready[1]), .busy(busy[1]), .err(err[1]));

   mini_mem_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(128), .WAIT_CYC(2)) u_d128 (
      .clk(clk), .rst_n(rst_n[2]), .rd_req(rd[2]), .wr_req(wr[2]), .addr(addr[2]),
      .wdata(wdata[2]), .rdata(rdata[2]), .ready(ready[2]), .busy(busy[2]), .err(err[2]));

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
      end
   endtask

   // One transfer, strobe dropped after the first cycle; lat = expected ready cycle.
   task automatic xfer(input int k, input bit is_wr, input logic [7:0] a, input logic [7:0] d,
                       input int lat, input bit exp_err, input logic [7:0] exp_rd);
      string tag;
      @(negedge clk);
      rd[k] = !is_wr; wr[k] = is_wr; addr[k] = a; wdata[k] = d;
      for (int c = 1; c <= lat + 1; c++) begin
         @(negedge clk);
         tag = $sformatf("d%0d %s@%0h c%0d", k, is_wr ? "wr" : "rd", a, c);
         check_eq({tag, " ready"}, 32'(ready[k]), 32'(c == lat));
         check_eq({tag, " busy"},  32'(busy[k]),  32'(c <= lat));
         check_eq({tag, " err"},   32'(err[k]),   32'((c == lat) && exp_err));
         if (c == lat) check_eq({tag, " rdata"}, 32'(rdata[k]), 32'(exp_rd));
         if (c == 1) begin
            rd[k] = 1'b0; wr[k] = 1'b0; addr[k] = ~a; wdata[k] = ~d;
         end
      end
   endtask

   // Both strobes high in IDLE: one err cycle, nothing else.
   task automatic bad_req(input int k, input logic [7:0] a, input logic [7:0] d);
      @(negedge clk);
      rd[k] = 1'b1; wr[k] = 1'b1; addr[k] = a; wdata[k] = d;
      @(negedge clk);
      check_eq("both err", 32'(err[k]), 32'd1);
      check_eq("both ready", 32'(ready[k]), 32'd0);
      check_eq("both busy", 32'(busy[k]), 32'd0);
      rd[k] = 1'b0; wr[k] = 1'b0;
      @(negedge clk);
      check_eq("both err clr", 32'(err[k]), 32'd0);
      check_eq("both ready2", 32'(ready[k]), 32'd0);
   endtask

   // Write aborted by reset asserted in cycle at_c of the transfer.
   task automatic rst_mid(input int k, input logic [7:0] a, input logic [7:0] d, input int at_c);
      @(negedge clk);
      wr[k] = 1'b1; addr[k] = a; wdata[k] = d;
      for (int c = 1; c <= at_c; c++) begin
         @(negedge clk);
         if (c == 1) wr[k] = 1'b0;
      end
      check_eq($sformatf("rstmid c%0d busy", at_c), 32'(busy[k]), 32'd1);
      rst_n[k] = 1'b0;
      @(negedge clk);
      check_eq("rstmid ready", 32'(ready[k]), 32'd0);
      check_eq("rstmid busy0", 32'(busy[k]), 32'd0);
      check_eq("rstmid rdata", 32'(rdata[k]), 32'd0);
      rst_n[k] = 1'b1;
      @(negedge clk);
      check_eq("rstmid ready after", 32'(ready[k]), 32'd0);
      check_eq("rstmid busy after", 32'(busy[k]), 32'd0);
   endtask

   // Read strobe held through ready: second ready lat+1 cycles after the first.
   task automatic hold_rd(input int k, input logic [7:0] a, input logic [7:0] exp_rd, input int lat);
      string tag;
      @(negedge clk);
      rd[k] = 1'b1; addr[k] = a;
      for (int c = 1; c <= 2 * lat + 2; c++) begin
         @(negedge clk);
         tag = $sformatf("d%0d hold c%0d", k, c);
         check_eq({tag, " ready"}, 32'(ready[k]), 32'((c == lat) || (c == 2 * lat + 1)));
         check_eq({tag, " busy"}, 32'(busy[k]),
                  32'((c <= lat) || ((c >= lat + 2) && (c <= 2 * lat + 1))));
         if (c == 2 * lat + 1) begin
            check_eq({tag, " rdata"}, 32'(rdata[k]), 32'(exp_rd));
            rd[k] = 1'b0;
         end
      end
   endtask

   initial begin
      for (int k = 0; k < NDUT; k++) begin
         rst_n[k] = 1'b0; rd[k] = 1'b0; wr[k] = 1'b0; addr[k] = '0; wdata[k] = '0;
      end
      repeat (2) @(negedge clk);
      for (int k = 0; k < NDUT; k++) begin
         check_eq($sformatf("d%0d rst rdata", k), 32'(rdata[k]), 32'd0);
         check_eq($sformatf("d%0d rst ready", k), 32'(ready[k]), 32'd0);
         check_eq($sformatf("d%0d rst busy", k),  32'(busy[k]),  32'd0);
         check_eq($sformatf("d%0d rst err", k),   32'(err[k]),   32'd0);
         rst_n[k] = 1'b1;
      end

      // Two wait states, full depth
      xfer(0, 1'b1, 8'h10, 8'hA5, 3, 1'b0, 8'h00);
      xfer(0, 1'b0, 8'h10, 8'h00, 3, 1'b0, 8'hA5);
      xfer(0, 1'b1, 8'h20, 8'h5A, 3, 1'b0, 8'hA5);
      xfer(0, 1'b0, 8'h20, 8'h00, 3, 1'b0, 8'h5A);
      xfer(0, 1'b0, 8'h10, 8'h00, 3, 1'b0, 8'hA5);
      bad_req(0, 8'h10, 8'h77);
      xfer(0, 1'b0, 8'h10, 8'h00, 3, 1'b0, 8'hA5);
      rst_mid(0, 8'h10, 8'hFF, 1);
      xfer(0, 1'b0, 8'h10, 8'h00, 3, 1'b0, 8'hA5);
      rst_mid(0, 8'h10, 8'hFF, 3);
      xfer(0, 1'b0, 8'h10, 8'h00, 3, 1'b0, 8'hA5);
      hold_rd(0, 8'h10, 8'hA5, 3);

      // Zero wait states
      xfer(1, 1'b1, 8'h10, 8'hA5, 1, 1'b0, 8'h00);
      xfer(1, 1'b0, 8'h10, 8'h00, 1, 1'b0, 8'hA5);
      hold_rd(1, 8'h10, 8'hA5, 1);

      // 128-deep: 8'h90 is out of range and must not alias onto 8'h10
      xfer(2, 1'b1, 8'h10, 8'hA5, 3, 1'b0, 8'h00);
      xfer(2, 1'b0, 8'h10, 8'h00, 3, 1'b0, 8'hA5);
      xfer(2, 1'b1, 8'h90, 8'h3C, 3, 1'b1, 8'hA5);
      xfer(2, 1'b0, 8'h90, 8'h00, 3, 1'b1, 8'hA5);
      xfer(2, 1'b0, 8'h10, 8'h00, 3, 1'b0, 8'hA5);
      xfer(2, 1'b1, 8'h7F, 8'hC3, 3, 1'b0, 8'hA5);
      xfer(2, 1'b0, 8'h7F, 8'h00, 3, 1'b0, 8'hC3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
